// File: rtl/mmu_pkg.sv
// Shared types and constants for the systolic MMU controller.
//   sys_op_e          : command opcode carried on cmd_op
//   sys_ctrl_state_e  : sequencer state encoding
//   SYS_PIPE_LAT      : cycles from the first activation read until the last
//                       psum reaches the array bottom (default array size)
package mmu_pkg;

  localparam int SYS_ROW_DEF    = 16;
  localparam int SYS_COL_DEF    = 16;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 16;

  localparam int SYS_PIPE_LAT = SYS_ROW_DEF + SYS_COL_DEF;

  typedef enum logic {
    LOAD_W  = 1'b0,
    COMPUTE = 1'b1
  } sys_op_e;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WFLUSH,
    WCOMMIT,
    STREAM,
    DRAIN,
    FIN
  } sys_ctrl_state_e;

  function automatic int pipe_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/skew_pipe.sv
// 1-bit delay line with every stage exposed as a tap.
//   clk   : clock
//   clr_n : synchronous active-low clear of all stages
//   d     : input bit
//   q     : q[i] is d delayed by i+1 cycles
module skew_pipe #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  // The cast keeps the low DEPTH bits, so DEPTH=1 needs no special case.
  always_ff @(posedge clk) begin
    if (!clr_n) q <= '0;
    else        q <= DEPTH'({q, d});
  end

endmodule

// File: rtl/sys_ctrl.sv
// Sequencer for the weight-stationary systolic MMU.
//   cmd_*        : one-at-a-time command handshake (LOAD_W / COMPUTE)
//   w_rd_*       : weight buffer reads, w_wen / global_w_wen drive the array
//   act_rd_*     : activation buffer reads
//   row_en       : per-row enable with diagonal skew
//   col_valid    : per-column psum valid at the array bottom
//   busy/done/err: status; err is sticky until reset
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready=1
// WLOAD   | reading SYS_ROW weight rows
// WFLUSH  | last weight row shifting into the array
// WCOMMIT | global weight commit, done pulse
// STREAM  | reading N activation vectors
// DRAIN   | waiting for the skew lines to empty
// FIN     | done pulse, back to IDLE
module sys_ctrl
  import mmu_pkg::*;
#(
  parameter int SYS_ROW    = SYS_ROW_DEF,
  parameter int SYS_COL    = SYS_COL_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_rd_addr,
  output logic [SYS_COL-1:0]    w_wen,
  output logic [SYS_COL-1:0]    global_w_wen,
  output logic                  act_rd_en,
  output logic [ADDR_WIDTH-1:0] act_rd_addr,
  output logic [SYS_ROW-1:0]    row_en,
  output logic [SYS_COL-1:0]    col_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // The last col_valid stage empties on its own during the FIN cycle, so
  // it is excluded when deciding that the pipeline has drained.
  localparam logic [SYS_COL-1:0] COL_MASK = {SYS_COL{1'b1}} >> 1;

  sys_ctrl_state_e      state;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 w_loaded;
  logic                 w_wen_bit;
  logic                 pending;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign w_wen     = {SYS_COL{w_wen_bit}};
  assign pending   = act_rd_en | (|row_en) | (|(col_valid & COL_MASK));

  skew_pipe #(.DEPTH(SYS_ROW)) u_row_skew (
    .clk   (clk),
    .clr_n (rstn),
    .d     (act_rd_en),
    .q     (row_en)
  );

  skew_pipe #(.DEPTH(SYS_COL)) u_col_skew (
    .clk   (clk),
    .clr_n (rstn),
    .d     (row_en[SYS_ROW-1]),
    .q     (col_valid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      w_loaded     <= 1'b0;
      w_wen_bit    <= 1'b0;
      w_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      global_w_wen <= '0;
      act_rd_en    <= 1'b0;
      act_rd_addr  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      global_w_wen <= '0;
      w_wen_bit    <= w_rd_en;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (sys_op_e'(cmd_op) == LOAD_W) begin
              state     <= WLOAD;
              w_rd_en   <= 1'b1;
              w_rd_addr <= cmd_addr;
              cnt       <= LEN_WIDTH'(SYS_ROW - 1);
            end else if (!w_loaded || cmd_len == '0) begin
              err   <= err | ~w_loaded;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state       <= STREAM;
              act_rd_en   <= 1'b1;
              act_rd_addr <= cmd_addr;
              cnt         <= cmd_len - 1'b1;
            end
          end
        end
        WLOAD: begin
          if (cnt == '0) begin
            w_rd_en <= 1'b0;
            state   <= WFLUSH;
          end else begin
            cnt       <= cnt - 1'b1;
            w_rd_addr <= w_rd_addr + 1'b1;
          end
        end
        WFLUSH: begin
          global_w_wen <= '1;
          done         <= 1'b1;
          w_loaded     <= 1'b1;
          state        <= WCOMMIT;
        end
        WCOMMIT: state <= IDLE;
        STREAM: begin
          if (cnt == '0) begin
            act_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt         <= cnt - 1'b1;
            act_rd_addr <= act_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (!pending) begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl (4x4 array). Commands are issued with random
// fields; a timing model derived from the command rules pushes expected
// output events per stream, and a monitor pops and compares them.
module tb_sys_ctrl;
  import mmu_pkg::*;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int LW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [C-1:0]  w_wen;
  logic [C-1:0]  global_w_wen;
  logic          act_rd_en;
  logic [AW-1:0] act_rd_addr;
  logic [R-1:0]  row_en;
  logic [C-1:0]  col_valid;
  logic          busy;
  logic          done;
  logic          err;

  sys_ctrl #(.SYS_ROW(R), .SYS_COL(C), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_wen(w_wen),
    .global_w_wen(global_w_wen), .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr), .row_en(row_en), .col_valid(col_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  // streams: 0 w_rd, 1 w_wen, 2 global_w_wen, 3 act_rd, 4 row_en, 5 col_valid, 6 done
  ev_t q[7][$];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int busy_from = -1, busy_to = -2;
  int err_from = -1, err_until = -1;
  bit w_loaded_m = 1'b0;

  function automatic string sname(input int i);
    case (i)
      0: return "w_rd";
      1: return "w_wen";
      2: return "global_w_wen";
      3: return "act_rd";
      4: return "row_en";
      5: return "col_valid";
      default: return "done";
    endcase
  endfunction

  task automatic push_ev(input int i, input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q[i].push_back(e);
  endtask

  // Expected behaviour of one accepted command, in absolute cycle numbers.
  task automatic model_cmd(input int a, input bit op, input int base, input int n);
    int s, fin;
    logic [31:0] vec;
    if (op == 1'b0) begin
      for (int k = 0; k < R; k++) push_ev(0, a + 1 + k, (base + k) % 65536);
      for (int t = a + 2; t <= a + R + 1; t++) push_ev(1, t, 32'hF);
      push_ev(2, a + R + 2, 32'hF);
      push_ev(6, a + R + 2, 32'h1);
      busy_from = a + 1;
      busy_to = a + R + 2;
      w_loaded_m = 1'b1;
    end else if (!w_loaded_m || n == 0) begin
      if (!w_loaded_m && (err_from < 0 || err_until >= 0)) begin
        err_from = a + 1;
        err_until = -1;
      end
      push_ev(6, a + 1, 32'h1);
      busy_from = a + 1;
      busy_to = a + 1;
    end else begin
      s = a + 1;
      for (int i = 0; i < n; i++) push_ev(3, s + i, (base + i) % 65536);
      for (int t = s + 1; t <= s + n + R - 1; t++) begin
        vec = '0;
        for (int r = 0; r < R; r++)
          if (t >= s + 1 + r && t <= s + n + r) vec[r] = 1'b1;
        if (vec != 0) push_ev(4, t, vec);
      end
      for (int t = s + R + 1; t <= s + R + n + C - 1; t++) begin
        vec = '0;
        for (int c = 0; c < C; c++)
          if (t >= s + R + 1 + c && t <= s + R + n + c) vec[c] = 1'b1;
        if (vec != 0) push_ev(5, t, vec);
      end
      fin = s + n + R + C;
      push_ev(6, fin, 32'h1);
      busy_from = a + 1;
      busy_to = fin;
    end
  endtask

  // Offer a command and return the cycle in which it was accepted; cmd_valid
  // stays high on return so a following call keeps it asserted.
  task automatic issue(input bit op, input int base, input int n, output int a);
    int b;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = base[15:0];
    cmd_len = n[15:0];
    b = 0;
    while (!cmd_ready && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles, required 1", cmd_ready, b);
    end
    a = cyc;
    model_cmd(a, op, base, n);
  endtask

  task automatic release_cmd();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic reset_now();
    int t;
    t = cyc;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++)
      while (q[i].size() > 0 && q[i][q[i].size()-1].cyc > t) void'(q[i].pop_back());
    if (busy_to > t) busy_to = t;
    if (err_from >= 0 && err_until < 0) err_until = t;
    w_loaded_m = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    bit act[7];
    logic [31:0] val[7];
    bit exp_now, exp_busy, exp_err;
    if (mon_en) begin
      act[0] = w_rd_en;            val[0] = 32'(w_rd_addr);
      act[1] = |w_wen;             val[1] = 32'(w_wen);
      act[2] = |global_w_wen;      val[2] = 32'(global_w_wen);
      act[3] = act_rd_en;          val[3] = 32'(act_rd_addr);
      act[4] = |row_en;            val[4] = 32'(row_en);
      act[5] = |col_valid;         val[5] = 32'(col_valid);
      act[6] = done;               val[6] = 32'(done);
      for (int i = 0; i < 7; i++) begin
        while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s_missing: cycle %0d had no event, required 0x%0h", sname(i), q[i][0].cyc, q[i][0].val);
          void'(q[i].pop_front());
        end
        exp_now = (q[i].size() > 0 && q[i][0].cyc == cyc);
        if (exp_now || act[i]) begin
          n_chk++;
          if (!exp_now) begin
            n_fail++;
            $display("FAIL %s_unexpected: cycle %0d got 0x%0h, required idle", sname(i), cyc, val[i]);
          end else begin
            if (!act[i] || val[i] != q[i][0].val) begin
              n_fail++;
              $display("FAIL %s_value: cycle %0d got active=%0b 0x%0h, required 0x%0h", sname(i), cyc, act[i], val[i], q[i][0].val);
            end
            void'(q[i].pop_front());
          end
        end
      end
      exp_busy = (cyc >= busy_from && cyc <= busy_to);
      exp_err = (err_from >= 0 && cyc >= err_from && (err_until < 0 || cyc <= err_until));
      n_chk += 3;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy: cycle %0d got %0b, required %0b", cyc, busy, exp_busy);
      end
      if (cmd_ready !== !exp_busy) begin
        n_fail++;
        $display("FAIL cmd_ready: cycle %0d got %0b, required %0b", cyc, cmd_ready, !exp_busy);
      end
      if (err !== exp_err) begin
        n_fail++;
        $display("FAIL err: cycle %0d got %0b, required %0b", cyc, err, exp_err);
      end
    end
  end

  initial begin
    int a, a1, a2, b, op, n, base;
    bit any;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        w_rd_en !== 1'b0 || act_rd_en !== 1'b0 || row_en !== '0 || col_valid !== '0 ||
        w_wen !== '0 || global_w_wen !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%0b busy=%0b done=%0b err=%0b row_en=%0h col_valid=%0h, required ready=1 rest 0",
               cmd_ready, busy, done, err, row_en, col_valid);
    end
    mon_en = 1'b1;

    // COMPUTE with no weights committed
    issue(1'b1, int'($urandom_range(0, 65535)), 5, a);
    release_cmd();
    // LOAD_W at 0x10, then COMPUTE 0x20 N=3, then N=0
    issue(1'b0, 32'h10, 0, a);
    release_cmd();
    issue(1'b1, 32'h20, 3, a);
    release_cmd();
    issue(1'b1, 32'h40, 0, a);
    release_cmd();
    // command held across a LOAD_W, wrapping address
    issue(1'b0, 32'h80, 0, a1);
    issue(1'b1, 32'hFFFE, 4, a2);
    n_chk++;
    if (a2 != a1 + R + 3) begin
      n_fail++;
      $display("FAIL held_accept: accepted cycle %0d, required %0d", a2, a1 + R + 3);
    end
    release_cmd();

    for (int k = 0; k < 20; k++) begin
      op = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, 65535));
      n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12));
      issue(op[0], base, n, a);
      if ($urandom_range(0, 2) != 0) begin
        release_cmd();
        repeat (int'($urandom_range(0, 3))) @(posedge clk);
        #1;
      end
    end
    release_cmd();

    // reset during DRAIN
    issue(1'b1, 32'h100, 5, a);
    release_cmd();
    b = 0;
    while (cyc < a + 8 && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    reset_now();
    repeat (2) @(posedge clk);
    #1;
    // weights are gone after reset
    issue(1'b1, 32'h200, 2, a);
    release_cmd();

    b = 0;
    any = 1'b1;
    while (any && b < 2000) begin
      @(posedge clk); #1;
      b++;
      any = 1'b0;
      for (int i = 0; i < 7; i++) if (q[i].size() > 0) any = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (q[i].size() != 0) begin
        n_fail++;
        $display("FAIL %s_drain: %0d events outstanding, required 0", sname(i), q[i].size());
      end
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
Sequencer for the weight-stationary systolic MMU (SYS_ROW rows of sys_row, SYS_COL PEs each).
- Accepts one command at a time over a valid/ready handshake: LOAD_W or COMPUTE.
- LOAD_W fetches SYS_ROW weight rows from the weight buffer, shifts them into the array, then commits them with a global weight-write pulse.
- COMPUTE streams N activation vectors with per-row diagonal enable skew, then flags per-column psum validity at the array bottom.

Parameters:
SYS_ROW, 16, number of array rows
SYS_COL, 16, number of PEs per row
LEN_WIDTH, 16, width of the command vector count
ADDR_WIDTH, 16, buffer address width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_op  in  1  0=LOAD_W, 1=COMPUTE
cmd_addr  in  ADDR_WIDTH  base address in the weight or activation buffer
cmd_len  in  LEN_WIDTH  COMPUTE vector count N (ignored for LOAD_W)
w_rd_en  out  1  weight buffer read strobe (read data arrives 1 cycle later)
w_rd_addr  out  ADDR_WIDTH  weight buffer address
w_wen  out  SYS_COL  weight shift enable to the top row, all bits equal
global_w_wen  out  SYS_COL  weight commit pulse, all bits equal
act_rd_en  out  1  activation buffer read strobe (read data arrives 1 cycle later)
act_rd_addr  out  ADDR_WIDTH  activation buffer address
row_en  out  SYS_ROW  en_in for each row's first PE
col_valid  out  SYS_COL  psum_out of the bottom row, column c, is valid
busy  out  1  state is not IDLE
done  out  1  one-cycle command completion pulse
err  out  1  sticky: COMPUTE was issued with no committed weights

Behaviour:
- Reset (rstn=0 at a clock edge):
  - All outputs go to 0, except cmd_ready=1.
  - FSM goes to IDLE; every delay line clears; w_loaded clears; err clears.
  - Reset mid-command aborts it with no done pulse.
- States: IDLE, WLOAD, WFLUSH, WCOMMIT, STREAM, DRAIN, FIN.
- cmd_ready = (state==IDLE).
  - Accept = cmd_valid && cmd_ready; cmd_addr and cmd_len are latched at accept.
- LOAD_W, with accept at cycle a:
  - WLOAD, cycles a+1..a+SYS_ROW: w_rd_en=1, w_rd_addr = base+k for k=0..SYS_ROW-1.
  - WFLUSH, 1 cycle.
  - w_wen = w_rd_en delayed 1, so it is high for cycles a+2..a+SYS_ROW+1.
  - WCOMMIT, cycle a+SYS_ROW+2: global_w_wen all-ones and done=1, both for one cycle. w_loaded is set. Next state is IDLE.
- COMPUTE with N>0 and w_loaded=1, with accept at cycle a; let s=a+1:
  - STREAM, cycles s..s+N-1: act_rd_en=1, act_rd_addr = base+i.
  - row_en[0] = act_rd_en delayed 1.
  - row_en[r] = row_en[r-1] delayed 1, so row r is first enabled at s+1+r.
  - col_valid[c] = row_en[SYS_ROW-1] delayed 1+c.
  - DRAIN holds until every delay line is empty.
  - FIN: done pulses exactly at cycle s+N+SYS_ROW+SYS_COL, then IDLE.
- COMPUTE with N=0: no reads and no enables; done pulses at a+1; then IDLE.
- COMPUTE with w_loaded=0: err is set (sticky); no reads; done pulses at a+1.
- LOAD_W does not clear w_loaded. A new LOAD_W replaces the weights only at its commit.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters are LEN_WIDTH wide, so N up to 2^LEN_WIDTH-1 is supported.
- cmd_valid while busy is ignored (cmd_ready=0). A held command is accepted in the cycle after the FSM returns to IDLE.
- No stall input: the buffers must sustain one read per cycle.

Decomposition:
- mmu_pkg holds:
  - sys_op_e (LOAD_W=0, COMPUTE=1);
  - sys_ctrl_state_e;
  - the latency constant SYS_PIPE_LAT = SYS_ROW+SYS_COL.
- Sub-module skew_pipe: a parameterised 1-bit delay line (DEPTH, with a tap vector) with synchronous active-low clear. It is used for the row_en skew and for the col_valid skew.

Test Plan:
1. Reset, then LOAD_W with addr=0x10 (SYS_ROW=4, SYS_COL=4 build) -> w_rd_addr 0x10..0x13 on cycles a+1..a+4; w_wen high a+2..a+5; global_w_wen=4'hF and done at a+6.
2. After LOAD_W, COMPUTE with addr=0x20, N=3 -> act_rd_addr 0x20..0x22; row_en[3] high s+4..s+6; col_valid[0] high s+5..s+7; col_valid[3] high s+8..s+10; done at s+11.
3. COMPUTE issued directly after reset -> err=1 at a+1 and stays 1; done at a+1; act_rd_en never asserted.
4. COMPUTE with N=0 -> done at a+1; row_en and col_valid stay 0; busy high for exactly 1 cycle.
5. cmd_valid held high across a LOAD_W -> no accept while busy; the second command is accepted the cycle after IDLE is re-entered. Address base 0xFFFE with N=4 wraps to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. rstn pulled low during DRAIN -> next cycle all row_en/col_valid=0; no done pulse; cmd_ready=1; err cleared.
